systolic_array_os: RTL

- Parametrised output-stationary systolic matrix-multiply engine computing C[ROWS x COLS] = A[ROWS x K] * B[K x COLS] with runtime K.
- Successor to the fixed 9x9 PE grid. Adds:
  - per-row and per-column input skewing
  - signed accumulation
  - an operand-stream handshake
  - a start/busy/done FSM
  - a backpressured result drain in row-major order
- Sits between the operand fetch logic and the AXI master write-data path. The out_* handshake maps directly onto WVALID/WREADY/WDATA.

---
 rtl/systolic_array_os.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/systolic_array_os.sv
// systolic_array_os: output-stationary ROWS x COLS signed matrix-multiply engine with skewed operand feed,
// start/busy/done control and a row-major backpressured drain. Define SYSTOLIC_SAT_EN for saturating accumulate.
module systolic_array_os #(
  parameter  int ROWS   = 4,
  parameter  int COLS   = 4,
  parameter  int DATA_W = 8,
  parameter  int ACC_W  = 32,
  parameter  int K_W    = 8,
  localparam int N      = ROWS * COLS,
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                     M_AXI_ACLK,
  input  logic                     M_AXI_ARESETN,
  input  logic                     start,
  input  logic [K_W-1:0]           k_len,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ROWS*DATA_W-1:0]   a_data,
  input  logic [COLS*DATA_W-1:0]   b_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_data,
  output logic [IDX_W-1:0]         out_index,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
`ifdef SYSTOLIC_SAT_EN
  ,
  output logic                     sat_flag
`endif
);
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;
  localparam int CNT_W = (K_W > $clog2(ROWS + COLS)) ? K_W : $clog2(ROWS + COLS);
  state_t                   state_q, state_d;
  logic [K_W-1:0]           k_q, k_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     done_q, done_d;
  logic                     clr, accept, en, hs, last_beat;
  logic signed [DATA_W-1:0] a_edge [ROWS];
  logic signed [DATA_W-1:0] b_edge [COLS];
  logic signed [DATA_W-1:0] a_pass [N];
  logic signed [DATA_W-1:0] b_pass [N];
  logic signed [ACC_W-1:0]  acc    [N];

  assign in_ready  = state_q == LOAD;
  assign accept    = in_valid && in_ready;
  assign en        = accept || state_q == FLUSH;
  assign clr       = state_q == IDLE && start;
  assign out_valid = state_q == DRAIN;
  assign hs        = out_valid && out_ready;
  assign out_index = idx_q;
  assign out_last  = out_valid && idx_q == IDX_W'(N - 1);
  assign out_data  = out_valid ? acc[idx_q] : '0;
  assign busy      = state_q != IDLE;
  assign done      = done_q;
  assign last_beat = cnt_q == CNT_W'(k_q) - CNT_W'(1);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        k_d     = k_len;
        cnt_d   = '0;
        idx_d   = '0;
        state_d = (k_len != '0) ? LOAD : DRAIN;
      end
      LOAD: if (accept) begin
        cnt_d   = last_beat ? '0 : cnt_q + 1'b1;
        state_d = last_beat ? FLUSH : LOAD;
      end
      FLUSH: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = (cnt_q == CNT_W'(ROWS + COLS - 2)) ? DRAIN : FLUSH;
      end
      DRAIN: if (hs) begin
        idx_d   = out_last ? '0 : idx_q + 1'b1;
        state_d = out_last ? IDLE : DRAIN;
        done_d  = out_last;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q <= IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Row r of A is delayed r ticks so its wavefront meets the matching B column.
  for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
    logic signed [DATA_W-1:0] a_in;
    assign a_in = accept ? a_data[(ROWS-1-r)*DATA_W +: DATA_W] : '0;
    if (r == 0) begin : g_direct
      assign a_edge[r] = a_in;
    end else begin : g_dly
      logic signed [DATA_W-1:0] d_q [r];
      always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
          d_q <= '{default: '0};
        end else if (clr) begin
          d_q <= '{default: '0};
        end else if (en) begin
          d_q[0] <= a_in;
          for (int m = 1; m < r; m++) d_q[m] <= d_q[m-1];
        end
      end
      assign a_edge[r] = d_q[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_b_skew
    logic signed [DATA_W-1:0] b_in;
    assign b_in = accept ? b_data[(COLS-1-c)*DATA_W +: DATA_W] : '0;
    if (c == 0) begin : g_direct
      assign b_edge[c] = b_in;
    end else begin : g_dly
      logic signed [DATA_W-1:0] d_q [c];
      always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
          d_q <= '{default: '0};
        end else if (clr) begin
          d_q <= '{default: '0};
        end else if (en) begin
          d_q[0] <= b_in;
          for (int m = 1; m < c; m++) d_q[m] <= d_q[m-1];
        end
      end
      assign b_edge[c] = d_q[c-1];
    end
  end

`ifdef SYSTOLIC_SAT_EN
  logic [N-1:0] sat;
  logic         sat_flag_q;
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) sat_flag_q <= 1'b0;
    else if (clr) sat_flag_q <= 1'b0;
    else if (en && |sat) sat_flag_q <= 1'b1;
  end
  assign sat_flag = sat_flag_q;
`endif

  // A flows right and B flows down one PE per tick; each PE keeps its own C element.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_pe
      localparam int P = r * COLS + c;
      logic signed [DATA_W-1:0]   a_l, b_t, a_q, b_q;
      logic signed [2*DATA_W-1:0] prod;
      logic signed [ACC_W-1:0]    prod_x, acc_q, acc_d;
      assign a_l    = (c == 0) ? a_edge[r] : a_pass[(c == 0) ? 0 : P - 1];
      assign b_t    = (r == 0) ? b_edge[c] : b_pass[(r == 0) ? 0 : P - COLS];
      assign prod   = (2*DATA_W)'(a_l) * (2*DATA_W)'(b_t);
      assign prod_x = ACC_W'(prod);
`ifdef SYSTOLIC_SAT_EN
      logic [ACC_W:0] sum;
      assign sum    = {acc_q[ACC_W-1], acc_q} + {prod_x[ACC_W-1], prod_x};
      assign sat[P] = sum[ACC_W] != sum[ACC_W-1];
      assign acc_d  = !sat[P] ? sum[ACC_W-1:0] :
                      sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`else
      assign acc_d  = acc_q + prod_x;
`endif
      always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
          a_q   <= '0;
          b_q   <= '0;
          acc_q <= '0;
        end else if (clr) begin
          a_q   <= '0;
          b_q   <= '0;
          acc_q <= '0;
        end else if (en) begin
          a_q   <= a_l;
          b_q   <= b_t;
          acc_q <= acc_d;
        end
      end
      assign a_pass[P] = a_q;
      assign b_pass[P] = b_q;
      assign acc[P]    = acc_q;
    end
  end
endmodule
